// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one 4-bit lookahead group per stage, valid/ready flow control.
// Optional build macro CLA_PIPE_SAT_EN clamps the sum to the signed limits on overflow.
module cla_pipe_adder #(
    parameter  int WIDTH = 16,
    localparam int LAT   = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [LAT-1:0]            v_q, v_d;
    logic [LAT-1:0]            c_q, c_d;
    logic [LAT-1:0][WIDTH-1:0] x_q, x_d;
    logic [LAT-1:0][WIDTH-1:0] y_q, y_d;
    logic [LAT-1:0][WIDTH-1:0] s_q, s_d;
    logic                      ovf_q, ovf_d;

    logic [LAT-1:0][WIDTH-1:0] x_in, y_in, s_in;
    logic [LAT-1:0]            c_in, v_in;
    logic [3:0]                gp, gg;
    logic [4:0]                gc;
    logic                      c_msb;
    logic                      advance;
    logic                      unused_pipe;

    assign advance   = ~v_q[LAT-1] | out_ready;
    assign in_ready  = advance;
    assign out_valid = v_q[LAT-1];
    assign sum       = s_q[LAT-1];
    assign cout      = c_q[LAT-1];
    assign ovf       = ovf_q;

    // Operand bits of groups already summed are dead in later stages.
    assign unused_pipe = ^{x_q, y_q};

    always_comb begin
        x_in    = '0;
        y_in    = '0;
        s_in    = '0;
        c_in    = '0;
        v_in    = '0;
        x_in[0] = a;
        y_in[0] = b ^ {WIDTH{sub}};
        c_in[0] = cin ^ sub;
        v_in[0] = in_valid;
        for (int k = 1; k < LAT; k++) begin
            x_in[k] = x_q[k-1];
            y_in[k] = y_q[k-1];
            s_in[k] = s_q[k-1];
            c_in[k] = c_q[k-1];
            v_in[k] = v_q[k-1];
        end

        x_d   = x_in;
        y_d   = y_in;
        s_d   = s_in;
        v_d   = v_in;
        c_d   = '0;
        gp    = '0;
        gg    = '0;
        gc    = '0;
        c_msb = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            gp    = x_in[k][4*k +: 4] ^ y_in[k][4*k +: 4];
            gg    = x_in[k][4*k +: 4] & y_in[k][4*k +: 4];
            gc[0] = c_in[k];
            for (int j = 0; j < 4; j++) begin
                gc[j+1] = gg[j] | (gp[j] & gc[j]);
            end
            s_d[k][4*k +: 4] = gp ^ gc[3:0];
            c_d[k]           = gc[4];
            c_msb            = gc[3];  // last iteration leaves the carry into the MSB
        end
        ovf_d = c_msb ^ c_d[LAT-1];

`ifdef CLA_PIPE_SAT_EN
        // Operand a is never inverted, so its sign bit still travels in x.
        if (ovf_d) begin
            s_d[LAT-1] = x_in[LAT-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                              : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            c_q   <= '0;
            x_q   <= '0;
            y_q   <= '0;
            s_q   <= '0;
            ovf_q <= 1'b0;
        end else if (advance) begin
            v_q   <= v_d;
            c_q   <= c_d;
            x_q   <= x_d;
            y_q   <= y_d;
            s_q   <= s_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder (WIDTH=16): directed vectors, mid-stream stall, reset with work in flight.
module tb_cla_pipe_adder;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic [15:0] s_sat;
        logic        co;
        logic        ov;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_i, b_i;
    logic        cin_i, sub_i;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout, ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int n_recv  = 0;
    int n_sent  = 0;
    int cyc     = 0;
    logic [17:0] exp_q[$];
    vec_t        tbl[14];

    cla_pipe_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a_i), .b(b_i), .cin(cin_i), .sub(sub_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic ci,
                                input logic sb, input logic [15:0] s, input logic [15:0] ss,
                                input logic co, input logic ov);
        vec_t v;
        v.a = a; v.b = b; v.cin = ci; v.sub = sb; v.s = s; v.s_sat = ss; v.co = co; v.ov = ov;
        return v;
    endfunction

    function automatic logic [17:0] exp_of(input vec_t v);
`ifdef CLA_PIPE_SAT_EN
        return {v.s_sat, v.co, v.ov};
`else
        return {v.s, v.co, v.ov};
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: outputs must match the queue head whenever valid, including while stalled.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL spurious_output: got sum=0x%0h cout=%0b ovf=%0b, expected no output",
                         sum, cout, ovf);
            end else begin
                if ({sum, cout, ovf} !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL result: got sum=0x%0h cout=%0b ovf=%0b, expected sum=0x%0h cout=%0b ovf=%0b",
                             sum, cout, ovf, exp_q[0][17:2], exp_q[0][1], exp_q[0][0]);
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    n_recv++;
                end
            end
        end
    end

    task automatic send(input vec_t v, output int acc);
        a_i = v.a; b_i = v.b; cin_i = v.cin; sub_i = v.sub;
        in_valid = 1'b1;
        acc = -1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, expected 1");
        end else begin
            exp_q.push_back(exp_of(v));
            n_sent++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic check_latency(input string name, input int acc);
        int lat;
        lat = -1;
        for (int t = 0; t < 20; t++) begin
            if (t > 0 || !out_valid) @(negedge clk);
            if (out_valid) begin
                lat = cyc - acc;
                break;
            end
        end
        check(name, lat, 4);
    endtask

    task automatic drain();
        for (int t = 0; t < 40 && exp_q.size() != 0; t++) @(posedge clk);
        check("drain_empty", exp_q.size(), 0);
        #1;
    endtask

    initial begin
        int acc;
        tbl[0]  = mk(16'h1234, 16'h0FFF, 0, 0, 16'h2233, 16'h2233, 0, 0);
        tbl[1]  = mk(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 16'h0000, 1, 0);
        tbl[2]  = mk(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 16'h7FFF, 0, 1);
        tbl[3]  = mk(16'h0005, 16'h0007, 0, 1, 16'hFFFE, 16'hFFFE, 0, 0);
        tbl[4]  = mk(16'h0001, 16'h0001, 0, 0, 16'h0002, 16'h0002, 0, 0);
        tbl[5]  = mk(16'h00FF, 16'h0001, 0, 0, 16'h0100, 16'h0100, 0, 0);
        tbl[6]  = mk(16'h0F0F, 16'h00F1, 0, 0, 16'h1000, 16'h1000, 0, 0);
        tbl[7]  = mk(16'h8000, 16'h8000, 0, 0, 16'h0000, 16'h8000, 1, 1);
        tbl[8]  = mk(16'h1000, 16'h0001, 0, 1, 16'h0FFF, 16'h0FFF, 1, 0);
        tbl[9]  = mk(16'h0000, 16'h0001, 0, 1, 16'hFFFF, 16'hFFFF, 0, 0);
        tbl[10] = mk(16'h8000, 16'h0001, 0, 1, 16'h7FFF, 16'h8000, 1, 1);
        tbl[11] = mk(16'h1234, 16'h4321, 1, 0, 16'h5556, 16'h5556, 0, 0);
        tbl[12] = mk(16'hAAAA, 16'h5555, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0);
        tbl[13] = mk(16'hFFFF, 16'hFFFF, 1, 0, 16'hFFFF, 16'hFFFF, 1, 0);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a_i = '0; b_i = '0; cin_i = 1'b0; sub_i = 1'b0;
        #3;
        check("reset_out_valid", out_valid, 0);
        check("reset_outputs", {sum, cout, ovf}, 0);
        check("reset_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        send(tbl[0], acc);
        check_latency("latency_first", acc);
        drain();
        for (int i = 1; i < 4; i++) begin
            send(tbl[i], acc);
            drain();
        end

        fork
            begin
                for (int i = 4; i < 14; i++) send(tbl[i], acc);
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("stream_count", n_recv, 14);

        for (int i = 4; i < 7; i++) send(tbl[i], acc);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_outputs", {sum, cout, ovf}, 0);
        check("midrst_in_ready", in_ready, 1);
        exp_q.delete();
        n_sent -= 3;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send(tbl[11], acc);
        check_latency("latency_after_reset", acc);
        drain();
        repeat (6) @(posedge clk);
        check("final_count", n_recv, n_sent);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish by 100000, expected finish");
        $fatal(1, "timeout");
    end

endmodule
